// File: rtl/space_key_decoder.sv
// PS/2 receiver that tracks the space bar as a held level with press/release pulses.
// The PS/2 lines are synchronized and glitch-filtered into the clk domain before framing.
module space_key_decoder #(
   parameter int          FILTER_LEN = 8,
   parameter int          TIMEOUT    = 130_000,
   parameter logic [7:0]  SPACE_CODE = 8'h29
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic space,
   output logic space_pressed,
   output logic space_released,
   output logic frame_err
);

   localparam int          CW          = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_LEN - 1);
   localparam logic [16:0] TIMEOUT_CNT = 17'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t          r_state, w_nextState;
   logic [1:0]      r_clkSync, r_dataSync;
   logic [CW-1:0]   r_filtCnt;
   logic            r_filtClk, r_fallTick;
   logic [16:0]     r_toCnt;
   logic [7:0]      r_shift;
   logic [2:0]      r_bitCnt;
   logic            r_parity;
   logic            r_break, r_ext;
   logic            r_space, r_spaceD, r_frameErr;
   logic            w_data, w_timeout, w_byteValid, w_frameErr;

   assign w_data = r_dataSync[1];

   // Idle PS/2 lines are high, so synchronizers reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clkSync  <= 2'b11;
         r_dataSync <= 2'b11;
      end else begin
         r_clkSync  <= {r_clkSync[0], ps2_clk};
         r_dataSync <= {r_dataSync[0], ps2_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filtCnt  <= '0;
         r_filtClk  <= 1'b1;
         r_fallTick <= 1'b0;
      end else begin
         r_fallTick <= 1'b0;
         if (r_clkSync[1] == r_filtClk) begin
            r_filtCnt <= '0;
         end else if (r_filtCnt == FILT_LAST) begin
            r_filtCnt  <= '0;
            r_filtClk  <= r_clkSync[1];
            r_fallTick <= ~r_clkSync[1];
         end else begin
            r_filtCnt <= r_filtCnt + 1'b1;
         end
      end
   end

   // Inter-edge watchdog: saturates at the limit so the abort condition stays asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_toCnt <= '0;
      end else if (r_fallTick || r_state == IDLE) begin
         r_toCnt <= '0;
      end else if (r_toCnt != TIMEOUT_CNT) begin
         r_toCnt <= r_toCnt + 17'd1;
      end
   end

   assign w_timeout = (r_state != IDLE) && (r_toCnt == TIMEOUT_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_byteValid = 1'b0;
      w_frameErr  = 1'b0;
      if (w_timeout) begin
         w_nextState = IDLE;
         w_frameErr  = 1'b1;
      end else if (r_fallTick) begin
         case (r_state)
            IDLE: begin
               if (w_data) w_frameErr  = 1'b1;
               else        w_nextState = DATA;
            end
            DATA: begin
               if (r_bitCnt == 3'd7) w_nextState = PARITY;
            end
            PARITY: w_nextState = STOP;
            STOP: begin
               w_nextState = IDLE;
               if (w_data && (^{r_shift, r_parity})) w_byteValid = 1'b1;
               else                                 w_frameErr  = 1'b1;
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift  <= '0;
         r_bitCnt <= '0;
         r_parity <= 1'b0;
      end else if (r_fallTick && !w_timeout) begin
         case (r_state)
            IDLE:   r_bitCnt <= '0;
            DATA: begin
               r_shift  <= {w_data, r_shift[7:1]};
               r_bitCnt <= r_bitCnt + 3'd1;
            end
            PARITY: r_parity <= w_data;
            default: ;
         endcase
      end
   end

   // Prefix bytes (E0/F0) arm flags that apply to the next ordinary code only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_break    <= 1'b0;
         r_ext      <= 1'b0;
         r_space    <= 1'b0;
         r_spaceD   <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         r_frameErr <= w_frameErr;
         r_spaceD   <= r_space;
         if (w_frameErr) begin
            r_break <= 1'b0;
            r_ext   <= 1'b0;
         end else if (w_byteValid) begin
            if (r_shift == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
               r_break <= 1'b1;
            end else begin
               if (r_shift == SPACE_CODE && !r_ext) r_space <= ~r_break;
               r_break <= 1'b0;
               r_ext   <= 1'b0;
            end
         end
      end
   end

   assign space          = r_space;
   assign space_pressed  = r_space & ~r_spaceD;
   assign space_released = ~r_space & r_spaceD;
   assign frame_err      = r_frameErr;

endmodule

// File: doc/space_key_decoder.md
# space_key_decoder

Receives the PS/2 keyboard serial stream and turns the space-bar make/break codes into a clean held level `space` plus single-cycle press and release pulses. It sits directly upstream of the power-bar renderer and the game logic: the bar fills while `space` is high and resets when it drops. All logic runs in the pixel-clock domain, and the asynchronous PS/2 lines are synchronized and filtered internally.

## Interface
- FILTER_LEN, 8: number of consecutive equal synchronized ps2_clk samples needed to change the filtered clock level.
- TIMEOUT, 130_000: idle clk cycles allowed between filtered ps2_clk falling edges inside a frame (≈2 ms at 65 MHz).
- SPACE_CODE, 8'h29: set-2 make code of the space bar.

- clk  in  1  pixel clock (65 MHz)
- rst  in  1  asynchronous, active-high reset
- ps2_clk  in  1  PS/2 clock from the keyboard, asynchronous
- ps2_data  in  1  PS/2 data from the keyboard, asynchronous
- space  out  1  high while the space bar is held
- space_pressed  out  1  one-cycle pulse on the 0→1 transition of space
- space_released  out  1  one-cycle pulse on the 1→0 transition of space
- frame_err  out  1  one-cycle pulse when a frame is rejected (start, parity, stop or timeout)

## Operation
- Reset: all outputs are 0, filtered clock is 1, FSM is in IDLE, and the break and extended flags are 0.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer. The filtered clock goes to 0 only after FILTER_LEN consecutive synchronized 0 samples, and back to 1 after FILTER_LEN consecutive 1 samples. `fall_tick` is a one-cycle pulse on each filtered 1→0 change.
- Frame FSM advances only on `fall_tick` and samples synchronized ps2_data on that tick.
  - IDLE: data 0 → DATA with bit_cnt=0. Data 1 → stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit, then → STOP.
  - STOP: accept the byte only if the stop bit is 1 and the data bits plus parity have an odd number of 1s. Otherwise pulse frame_err. Either way → IDLE.
- Timeout: a 17-bit counter is cleared on every fall_tick and counts while the FSM is not in IDLE. When it reaches TIMEOUT, go to IDLE, discard the partial byte and pulse frame_err.
- Byte decoder, for each accepted byte:
  - 8'hE0: set the extended flag.
  - 8'hF0: set the break flag.
  - Any other code: act on it, then clear both flags. Only a code equal to SPACE_CODE with extended=0 acts:
    - break=0: set space=1.
    - break=1: set space=0.
  - Extended 8'h29, and all other keys, leave space unchanged.
- A rejected frame clears both the break and extended flags.
- Typematic repeat: a make code while space=1 keeps space at 1 and does not pulse space_pressed. A break while space=0 does not pulse space_released.
- Pulses: space_pressed and space_released are generated from the registered space value and its one-cycle-delayed copy. They never overlap.

## Timing
- Pin-to-tick latency: fall_tick fires FILTER_LEN+2 cycles after ps2_clk falls at the pin, provided ps2_clk and ps2_data stay stable.
- space changes on the clk edge after the fall_tick of the stop bit. Total latency is FILTER_LEN+3 cycles after the stop bit's ps2_clk falling edge (11 cycles with defaults).
- space_pressed and space_released are high during the first cycle in which space shows its new value.
- frame_err is high the cycle after the offending fall_tick, or the cycle after the timeout count reaches TIMEOUT.
- rst asserted mid-frame takes effect immediately. After release, the remaining bits of the interrupted frame are treated as a new frame:
  - a 1 bit in IDLE is rejected;
  - a 0 bit starts a frame that later fails or times out.
  - space stays 0 until a complete valid make code arrives.
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no fall_tick.

## Test plan
- Make 8'h29 (odd parity bit 0, stop 1) at a 10 kHz PS/2 clock → space=1 and one space_pressed pulse, FILTER_LEN+3 cycles after the stop-bit falling edge.
- Sequence 29, 29, 29 (typematic), then F0, 29 → space stays 1 with exactly one space_pressed; then space=0 with exactly one space_released after the final stop bit.
- E0 29, then E0 F0 29 → space stays 0 with no pulses. A following plain 29 → space=1.
- Byte 8'h29 with a wrong parity bit → frame_err pulses once and space stays 0. A following valid 29 → space=1.
- Frame stopped after 4 data bits with ps2_clk held high for TIMEOUT+10 cycles → frame_err pulses once at the timeout. A following valid F0, 29 while space=1 → space=0.
- rst pulsed during bit 5 of a make 29 while space=1 → space=0 immediately with no space_released pulse. 3-cycle ps2_clk glitches afterwards produce no frame_err.
